vx_warp_barrier_ctl: RTL and testbench
======================================

# vx_warp_barrier_ctl

Local (per-core) warp barrier controller. It takes barrier-arrival requests from the warp control path, tracks per-barrier arrival counts and warp masks, and issues one registered release (barrier id plus warp mask) per cycle back to the warp scheduler. The scheduler clears the stall bits in that mask. Completed barriers are arbitrated round-robin, and warps terminated mid-barrier are removed from the pending state.

## Interface
- NUM_WARPS, default 4: warps per core; NW_WIDTH = max(1, clog2(NUM_WARPS)).
- NUM_BARRIERS, default 4: barrier slots; NB_WIDTH = max(1, clog2(NUM_BARRIERS)).
- TIMEOUT_CYCLES, default 65536: watchdog limit (only used with BARRIER_TIMEOUT_EN).
- clk  in  1  clock; single clock domain.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  barrier arrival request.
- req_ready  out  1  request accepted when req_valid && req_ready.
- req_wid  in  NW_WIDTH  arriving warp.
- req_bar_id  in  NB_WIDTH  barrier slot.
- req_size_m1  in  NW_WIDTH  number of participating warps minus 1.
- kill_valid  in  1  warp terminated (tmask went to zero).
- kill_wid  in  NW_WIDTH  terminated warp.
- rel_valid  out  1  release pending.
- rel_ready  in  1  scheduler accepts release.
- rel_bar_id  out  NB_WIDTH  released barrier.
- rel_mask  out  NUM_WARPS  warps to unstall.
- busy  out  1  any slot not IDLE.
- timeout_err  out  1  sticky watchdog flag (0 when feature compiled out).

## Operation
- Per-slot state: FSM {IDLE, GATHER, RELEASE}, counter ctr (NW_WIDTH bits), mask (NUM_WARPS bits), size_m1 latched on first arrival.
- req_ready = (state[req_bar_id] != RELEASE). Back-pressure is per slot.
- Accepted arrival in IDLE or GATHER:
  - if ctr == size_m1: slot goes to RELEASE with mask | (1<<wid); ctr is cleared.
  - otherwise: ctr+1, mask |= bit, slot goes to (or stays in) GATHER.
- size_m1 = 0: completes on the first arrival, IDLE -> RELEASE directly.
- Arrival whose wid is already set in mask: accepted and ignored (no count change).
- req_size_m1 is sampled on the first arrival only. Later values are ignored.
- kill_valid: for every GATHER slot with mask[kill_wid]=1, clear the bit and decrement ctr.
  - If the mask becomes 0 the slot returns to IDLE.
  - Kill does not affect RELEASE slots.
- Simultaneous arrival and kill of the same wid on the same slot: the kill wins; the arrival is consumed with no effect.
- Release arbitration: VX_rr_arbiter over slots in RELEASE.
  - The winner is loaded into the output register only when the output is empty or is firing that cycle.
  - On rel_valid && rel_ready the granted slot goes RELEASE -> IDLE with mask cleared.
- busy = OR of (state != IDLE) | rel_valid.

## Timing
- Reset (async assert, sync deassert by the top level): all slots IDLE, ctr = 0, mask = 0, rel_valid = 0, rel_bar_id = 0, rel_mask = 0, busy = 0, timeout_err = 0.
- Arrival completing a barrier at edge N: rel_valid = 1 after edge N+1 (1-cycle registered latency) if no other release is stalled.
- rel_* outputs stay stable while rel_valid && !rel_ready.
- Back-to-back releases are possible: a fire in cycle N lets the next winner appear at N+1.
- A slot leaves RELEASE on its fire edge. Its req_ready is high the next cycle.
- Only one arrival per cycle, so at most one slot completes per cycle. Multiple RELEASE slots queue via round-robin.

## Configuration
- BARRIER_TIMEOUT_EN defined: one 32-bit watchdog per slot.
  - Counts cycles in GATHER; clears on leaving GATHER.
  - Reaching TIMEOUT_CYCLES sets timeout_err, which stays set until reset. A runtime assert fires in simulation.
- BARRIER_TIMEOUT_EN undefined: no counters; timeout_err tied to 0.

## Structure
- VX_gpu_pkg holds NW_WIDTH, NB_WIDTH and the slot-state enum (BAR_IDLE, BAR_GATHER, BAR_RELEASE).
- The barrier request and release payload structs also live in VX_gpu_pkg, so the scheduler and warp control path share them.
- Sub-module: the existing VX_rr_arbiter (N = NUM_BARRIERS) for release selection. Everything else is inline.
- Target size: about 200 lines of RTL.

## Test plan
- size_m1 = 2, arrivals wid 0, 1, 3 on bar 1 in consecutive cycles -> one release, bar_id = 1, mask = 4'b1011, one cycle after the third arrival; slot back to IDLE.
- size_m1 = 0, wid 2 on bar 0 -> rel_mask = 4'b0100 on the next cycle.
- Complete bar 0 and bar 2 while rel_ready = 0 -> req_ready low for ids 0 and 2, high for id 1; raise rel_ready -> releases for bar 0 then bar 2, one per cycle, with outputs stable while stalled.
- Bar 3 gathers wid 0 and 1 (size_m1 = 3), then kill wid 1 -> mask = 4'b0001, ctr = 1; kill wid 0 -> slot IDLE, busy = 0.
- Duplicate arrival of wid 2, and same-cycle arrival plus kill of wid 1 -> no count change; barrier completes only after the genuine remaining arrivals.
- With BARRIER_TIMEOUT_EN and TIMEOUT_CYCLES = 16, a single arrival with size_m1 = 1 -> timeout_err rises after 16 GATHER cycles and stays high; async reset_n low mid-GATHER -> all outputs at reset values immediately.

Source files
------------

// File: rtl/VX_gpu_pkg.sv
// Shared GPU core types: warp/barrier widths, barrier slot states and the
// barrier request/release payloads used by the scheduler and warp control path.
package VX_gpu_pkg;

    localparam int unsigned NUM_WARPS_CFG    = 4;
    localparam int unsigned NUM_BARRIERS_CFG = 4;
    localparam int unsigned NW_WIDTH = (NUM_WARPS_CFG > 1) ? $clog2(NUM_WARPS_CFG) : 1;
    localparam int unsigned NB_WIDTH = (NUM_BARRIERS_CFG > 1) ? $clog2(NUM_BARRIERS_CFG) : 1;

    typedef enum logic [1:0] {
        BAR_IDLE    = 2'd0,
        BAR_GATHER  = 2'd1,
        BAR_RELEASE = 2'd2
    } bar_state_e;

    typedef struct packed {
        logic [NW_WIDTH-1:0] wid;
        logic [NB_WIDTH-1:0] bar_id;
        logic [NW_WIDTH-1:0] size_m1;
    } bar_req_t;

    typedef struct packed {
        logic [NB_WIDTH-1:0]      bar_id;
        logic [NUM_WARPS_CFG-1:0] mask;
    } bar_rel_t;

    function automatic logic [NUM_WARPS_CFG-1:0] wid_bit(input logic [NW_WIDTH-1:0] wid);
        return NUM_WARPS_CFG'(1) << wid;
    endfunction

endpackage

// File: rtl/VX_rr_arbiter.sv
// Round-robin arbiter: the requester after the last granted index has priority;
// the pointer advances only when the grant is consumed.
module VX_rr_arbiter #(
    parameter int unsigned N     = 4,
    parameter int unsigned LOG_N = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [N-1:0]     requests,
    input  logic             grant_ready,
    output logic             grant_valid_c,
    output logic [LOG_N-1:0] grant_index_c
);

    logic [LOG_N-1:0] last_q;
    logic [LOG_N-1:0] cand;

    // Scan farthest-to-nearest so the nearest requester after last_q wins.
    always_comb begin
        grant_valid_c = 1'b0;
        grant_index_c = '0;
        cand          = '0;
        for (int unsigned i = N; i >= 1; i--) begin
            cand = LOG_N'((32'(last_q) + i) % N);
            if (requests[cand]) begin
                grant_valid_c = 1'b1;
                grant_index_c = cand;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_q <= LOG_N'(N - 1);
        end else if (grant_valid_c && grant_ready) begin
            last_q <= grant_index_c;
        end
    end

endmodule

// File: rtl/vx_warp_barrier_ctl.sv
// Per-core warp barrier controller: gathers arrivals per slot and issues one
// registered release per cycle. Optional watchdog under BARRIER_TIMEOUT_EN.
module vx_warp_barrier_ctl
    import VX_gpu_pkg::*;
#(
    parameter int unsigned NUM_WARPS      = NUM_WARPS_CFG,
    parameter int unsigned NUM_BARRIERS   = NUM_BARRIERS_CFG,
    parameter int unsigned TIMEOUT_CYCLES = 65536
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [NW_WIDTH-1:0]  req_wid,
    input  logic [NB_WIDTH-1:0]  req_bar_id,
    input  logic [NW_WIDTH-1:0]  req_size_m1,
    input  logic                 kill_valid,
    input  logic [NW_WIDTH-1:0]  kill_wid,
    output logic                 rel_valid,
    input  logic                 rel_ready,
    output logic [NB_WIDTH-1:0]  rel_bar_id,
    output logic [NUM_WARPS-1:0] rel_mask,
    output logic                 busy,
    output logic                 timeout_err
);

    bar_state_e           slot_state   [NUM_BARRIERS];
    bar_state_e           slot_state_n [NUM_BARRIERS];
    logic [NW_WIDTH-1:0]  slot_ctr     [NUM_BARRIERS];
    logic [NW_WIDTH-1:0]  slot_ctr_n   [NUM_BARRIERS];
    logic [NUM_WARPS-1:0] slot_mask    [NUM_BARRIERS];
    logic [NUM_WARPS-1:0] slot_mask_n  [NUM_BARRIERS];
    logic [NW_WIDTH-1:0]  slot_size    [NUM_BARRIERS];
    logic [NW_WIDTH-1:0]  slot_size_n  [NUM_BARRIERS];

    bar_req_t             req;
    bar_rel_t             rel_q, rel_n;
    logic                 rel_valid_q, rel_valid_n;
    logic                 busy_q, busy_n;
    logic                 rel_fire;
    logic                 out_load;
    logic [NUM_BARRIERS-1:0] arb_req;
    logic                 grant_valid;
    logic [NB_WIDTH-1:0]  grant_index;

    logic                 kill_hit, arr_hit;
    logic [NUM_WARPS-1:0] mask_k;
    logic [NW_WIDTH-1:0]  ctr_k, size_eff;

    assign req       = '{wid: req_wid, bar_id: req_bar_id, size_m1: req_size_m1};
    assign req_ready = (slot_state[req.bar_id] != BAR_RELEASE);
    assign rel_fire  = rel_valid_q && rel_ready;
    assign out_load  = !rel_valid_q || rel_ready;

    // A slot already sitting in the output register must not be granted twice.
    always_comb begin
        arb_req = '0;
        for (int unsigned b = 0; b < NUM_BARRIERS; b++) begin
            arb_req[b] = (slot_state[b] == BAR_RELEASE) &&
                         !(rel_valid_q && (rel_q.bar_id == NB_WIDTH'(b)));
        end
    end

    VX_rr_arbiter #(.N(NUM_BARRIERS), .LOG_N(NB_WIDTH)) u_rel_arb (
        .clk           (clk),
        .reset_n       (reset_n),
        .requests      (arb_req),
        .grant_ready   (out_load),
        .grant_valid_c (grant_valid),
        .grant_index_c (grant_index)
    );

    // Next state of all slots and of the release output register.
    always_comb begin
        slot_state_n = slot_state;
        slot_ctr_n   = slot_ctr;
        slot_mask_n  = slot_mask;
        slot_size_n  = slot_size;
        rel_n        = rel_q;
        rel_valid_n  = rel_valid_q;
        busy_n       = 1'b0;
        kill_hit     = 1'b0;
        arr_hit      = 1'b0;
        mask_k       = '0;
        ctr_k        = '0;
        size_eff     = '0;

        for (int unsigned b = 0; b < NUM_BARRIERS; b++) begin
            kill_hit = kill_valid && (slot_state[b] == BAR_GATHER) && slot_mask[b][kill_wid];
            arr_hit  = req_valid && req_ready && (req.bar_id == NB_WIDTH'(b)) &&
                       !(kill_valid && (kill_wid == req.wid)) && !slot_mask[b][req.wid];
            mask_k   = kill_hit ? (slot_mask[b] & ~wid_bit(kill_wid)) : slot_mask[b];
            ctr_k    = kill_hit ? (slot_ctr[b] - NW_WIDTH'(1)) : slot_ctr[b];
            size_eff = (slot_state[b] == BAR_IDLE) ? req.size_m1 : slot_size[b];

            if (rel_fire && (rel_q.bar_id == NB_WIDTH'(b))) begin
                slot_state_n[b] = BAR_IDLE;
                slot_mask_n[b]  = '0;
                slot_ctr_n[b]   = '0;
            end else if (arr_hit) begin
                slot_size_n[b] = size_eff;
                slot_mask_n[b] = mask_k | wid_bit(req.wid);
                if (ctr_k == size_eff) begin
                    slot_state_n[b] = BAR_RELEASE;
                    slot_ctr_n[b]   = '0;
                end else begin
                    slot_state_n[b] = BAR_GATHER;
                    slot_ctr_n[b]   = ctr_k + NW_WIDTH'(1);
                end
            end else if (kill_hit) begin
                slot_mask_n[b]  = mask_k;
                slot_ctr_n[b]   = ctr_k;
                slot_state_n[b] = (mask_k == '0) ? BAR_IDLE : BAR_GATHER;
            end
        end

        if (out_load) begin
            rel_valid_n = grant_valid;
            if (grant_valid) begin
                rel_n.bar_id = grant_index;
                rel_n.mask   = slot_mask[grant_index];
            end
        end

        busy_n = rel_valid_n;
        for (int unsigned b = 0; b < NUM_BARRIERS; b++) begin
            busy_n = busy_n | (slot_state_n[b] != BAR_IDLE);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned b = 0; b < NUM_BARRIERS; b++) begin
                slot_state[b] <= BAR_IDLE;
                slot_ctr[b]   <= '0;
                slot_mask[b]  <= '0;
                slot_size[b]  <= '0;
            end
            rel_q       <= '0;
            rel_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            slot_state  <= slot_state_n;
            slot_ctr    <= slot_ctr_n;
            slot_mask   <= slot_mask_n;
            slot_size   <= slot_size_n;
            rel_q       <= rel_n;
            rel_valid_q <= rel_valid_n;
            busy_q      <= busy_n;
        end
    end

    assign rel_valid  = rel_valid_q;
    assign rel_bar_id = rel_q.bar_id;
    assign rel_mask   = rel_q.mask;
    assign busy       = busy_q;

`ifdef BARRIER_TIMEOUT_EN
    logic [31:0] wd_cnt [NUM_BARRIERS];
    logic        wd_hit;
    logic        timeout_q;

    always_comb begin
        wd_hit = 1'b0;
        for (int unsigned b = 0; b < NUM_BARRIERS; b++) begin
            wd_hit = wd_hit | (wd_cnt[b] == 32'(TIMEOUT_CYCLES));
        end
    end

    // Watchdog counts GATHER cycles and saturates at the limit; the error is sticky.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned b = 0; b < NUM_BARRIERS; b++) begin
                wd_cnt[b] <= '0;
            end
            timeout_q <= 1'b0;
        end else begin
            for (int unsigned b = 0; b < NUM_BARRIERS; b++) begin
                if (slot_state[b] != BAR_GATHER) begin
                    wd_cnt[b] <= '0;
                end else if (wd_cnt[b] != 32'(TIMEOUT_CYCLES)) begin
                    wd_cnt[b] <= wd_cnt[b] + 32'd1;
                end
            end
            timeout_q <= timeout_q | wd_hit;
        end
    end

    always @(posedge clk) begin
        if (reset_n) begin
            assert (!(wd_hit && !timeout_q)) else $error("barrier watchdog expired");
        end
    end

    assign timeout_err = timeout_q;
`else
    logic [31:0] unused_timeout;
    assign unused_timeout = 32'(TIMEOUT_CYCLES);
    assign timeout_err    = 1'b0;
`endif

endmodule

// File: tb/tb_vx_warp_barrier_ctl.sv
// Directed bench for vx_warp_barrier_ctl: gather, release, back-pressure,
// kill handling, duplicate arrivals and async reset.
module tb_vx_warp_barrier_ctl;
    import VX_gpu_pkg::*;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       req_valid;
    logic       req_ready;
    logic [1:0] req_wid;
    logic [1:0] req_bar_id;
    logic [1:0] req_size_m1;
    logic       kill_valid;
    logic [1:0] kill_wid;
    logic       rel_valid;
    logic       rel_ready;
    logic [1:0] rel_bar_id;
    logic [3:0] rel_mask;
    logic       busy;
    logic       timeout_err;

    int n_checks = 0;
    int n_errors = 0;

`ifdef BARRIER_TIMEOUT_EN
    localparam logic EXP_TIMEOUT = 1'b1;
`else
    localparam logic EXP_TIMEOUT = 1'b0;
`endif

    always #5 clk = ~clk;

    vx_warp_barrier_ctl #(
        .NUM_WARPS      (4),
        .NUM_BARRIERS   (4),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_wid     (req_wid),
        .req_bar_id  (req_bar_id),
        .req_size_m1 (req_size_m1),
        .kill_valid  (kill_valid),
        .kill_wid    (kill_wid),
        .rel_valid   (rel_valid),
        .rel_ready   (rel_ready),
        .rel_bar_id  (rel_bar_id),
        .rel_mask    (rel_mask),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic arrive(input logic [1:0] wid, input logic [1:0] bar, input logic [1:0] sz);
        req_valid   = 1'b1;
        req_wid     = wid;
        req_bar_id  = bar;
        req_size_m1 = sz;
    endtask

    initial begin
        reset_n     = 1'b0;
        req_valid   = 1'b0;
        req_wid     = '0;
        req_bar_id  = '0;
        req_size_m1 = '0;
        kill_valid  = 1'b0;
        kill_wid    = '0;
        rel_ready   = 1'b1;
        #1;
        check("rst_rel_valid", 32'(rel_valid), 32'd0);
        check("rst_rel_bar_id", 32'(rel_bar_id), 32'd0);
        check("rst_rel_mask", 32'(rel_mask), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_timeout", 32'(timeout_err), 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        // Three-warp barrier on slot 1; later size_m1 values must be ignored
        arrive(2'd0, 2'd1, 2'd2); step();
        arrive(2'd1, 2'd1, 2'd0); step();
        check("t1_ctr_after2", 32'(dut.slot_ctr[1]), 32'd2);
        check("t1_no_early_rel", 32'(rel_valid), 32'd0);
        arrive(2'd3, 2'd1, 2'd0); step();
        req_valid = 1'b0;
        check("t1_latency_rel_low", 32'(rel_valid), 32'd0);
        check("t1_state_release", 32'(dut.slot_state[1]), 32'(BAR_RELEASE));
        step();
        check("t1_rel_valid", 32'(rel_valid), 32'd1);
        check("t1_rel_bar", 32'(rel_bar_id), 32'd1);
        check("t1_rel_mask", 32'(rel_mask), 32'b1011);
        check("t1_busy", 32'(busy), 32'd1);
        step();
        check("t1_rel_done", 32'(rel_valid), 32'd0);
        check("t1_state_idle", 32'(dut.slot_state[1]), 32'(BAR_IDLE));
        check("t1_busy_idle", 32'(busy), 32'd0);

        // Single-warp barrier completes on its first arrival
        arrive(2'd2, 2'd0, 2'd0); step();
        req_valid = 1'b0;
        check("t2_rel_low", 32'(rel_valid), 32'd0);
        step();
        check("t2_rel_valid", 32'(rel_valid), 32'd1);
        check("t2_rel_bar", 32'(rel_bar_id), 32'd0);
        check("t2_rel_mask", 32'(rel_mask), 32'b0100);
        step();
        check("t2_rel_done", 32'(rel_valid), 32'd0);

        // Two completions while the scheduler stalls
        rel_ready = 1'b0;
        arrive(2'd1, 2'd0, 2'd0); step();
        arrive(2'd3, 2'd2, 2'd0); step();
        req_valid = 1'b0;
        check("t3_rel_valid", 32'(rel_valid), 32'd1);
        check("t3_rel_bar0", 32'(rel_bar_id), 32'd0);
        check("t3_rel_mask0", 32'(rel_mask), 32'b0010);
        req_bar_id = 2'd0; #1;
        check("t3_ready_bar0", 32'(req_ready), 32'd0);
        req_bar_id = 2'd2; #1;
        check("t3_ready_bar2", 32'(req_ready), 32'd0);
        req_bar_id = 2'd1; #1;
        check("t3_ready_bar1", 32'(req_ready), 32'd1);
        step();
        check("t3_stall_valid", 32'(rel_valid), 32'd1);
        check("t3_stall_bar", 32'(rel_bar_id), 32'd0);
        check("t3_stall_mask", 32'(rel_mask), 32'b0010);
        rel_ready = 1'b1;
        step();
        check("t3_next_valid", 32'(rel_valid), 32'd1);
        check("t3_next_bar", 32'(rel_bar_id), 32'd2);
        check("t3_next_mask", 32'(rel_mask), 32'b1000);
        req_bar_id = 2'd0; #1;
        check("t3_ready_bar0_again", 32'(req_ready), 32'd1);
        step();
        check("t3_drained", 32'(rel_valid), 32'd0);
        check("t3_busy", 32'(busy), 32'd0);

        // Kill removes warps from a gathering slot
        arrive(2'd0, 2'd3, 2'd3); step();
        arrive(2'd1, 2'd3, 2'd3); step();
        req_valid = 1'b0;
        check("t4_mask_gather", 32'(dut.slot_mask[3]), 32'b0011);
        check("t4_ctr_gather", 32'(dut.slot_ctr[3]), 32'd2);
        kill_valid = 1'b1; kill_wid = 2'd1; step();
        kill_valid = 1'b0;
        check("t4_mask_kill1", 32'(dut.slot_mask[3]), 32'b0001);
        check("t4_ctr_kill1", 32'(dut.slot_ctr[3]), 32'd1);
        check("t4_busy_kill1", 32'(busy), 32'd1);
        kill_valid = 1'b1; kill_wid = 2'd0; step();
        kill_valid = 1'b0;
        check("t4_state_idle", 32'(dut.slot_state[3]), 32'(BAR_IDLE));
        check("t4_busy_idle", 32'(busy), 32'd0);

        // Duplicate arrival and arrival killed in the same cycle are ignored
        arrive(2'd2, 2'd2, 2'd2); step();
        arrive(2'd2, 2'd2, 2'd2); step();
        check("t5_dup_ctr", 32'(dut.slot_ctr[2]), 32'd1);
        check("t5_dup_mask", 32'(dut.slot_mask[2]), 32'b0100);
        arrive(2'd1, 2'd2, 2'd2);
        kill_valid = 1'b1; kill_wid = 2'd1; step();
        kill_valid = 1'b0;
        check("t5_killarr_ctr", 32'(dut.slot_ctr[2]), 32'd1);
        check("t5_killarr_mask", 32'(dut.slot_mask[2]), 32'b0100);
        arrive(2'd0, 2'd2, 2'd2); step();
        check("t5_ctr2", 32'(dut.slot_ctr[2]), 32'd2);
        check("t5_still_gather", 32'(dut.slot_state[2]), 32'(BAR_GATHER));
        arrive(2'd3, 2'd2, 2'd2); step();
        req_valid = 1'b0;
        check("t5_rel_low", 32'(rel_valid), 32'd0);
        step();
        check("t5_rel_valid", 32'(rel_valid), 32'd1);
        check("t5_rel_bar", 32'(rel_bar_id), 32'd2);
        check("t5_rel_mask", 32'(rel_mask), 32'b1101);
        step();
        check("t5_drained", 32'(rel_valid), 32'd0);

        // Stalled release plus a long GATHER, then asynchronous reset
        rel_ready = 1'b0;
        arrive(2'd1, 2'd0, 2'd0); step();
        arrive(2'd0, 2'd1, 2'd1); step();
        req_valid = 1'b0;
        check("t6_rel_valid", 32'(rel_valid), 32'd1);
        repeat (20) step();
        check("t6_timeout", 32'(timeout_err), 32'(EXP_TIMEOUT));
        #2;
        reset_n = 1'b0;
        #1;
        check("t6_rst_rel_valid", 32'(rel_valid), 32'd0);
        check("t6_rst_rel_bar", 32'(rel_bar_id), 32'd0);
        check("t6_rst_rel_mask", 32'(rel_mask), 32'd0);
        check("t6_rst_busy", 32'(busy), 32'd0);
        check("t6_rst_timeout", 32'(timeout_err), 32'd0);
        check("t6_rst_state", 32'(dut.slot_state[1]), 32'(BAR_IDLE));
        @(negedge clk);
        reset_n   = 1'b1;
        rel_ready = 1'b1;
        step();
        check("t6_post_busy", 32'(busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
